// File: rtl/idli_sqi_mem_m.sv
// SQI (quad-SPI) memory responder. It decodes command, address and data
// nibbles clocked in on the core's SCK/CS and serves them from an internal
// byte store. A byte-wide backdoor port is provided for program preload.
module idli_sqi_mem_m #(
    parameter int         ADDR_W    = 16,
    parameter logic [7:0] CMD_RD    = 8'h03,
    parameter logic [7:0] CMD_WR    = 8'h02,
    parameter int         DUMMY_NIB = 2
) (
    input  logic              i_smem_gck,
    input  logic              i_smem_rst,
    input  logic              i_smem_sck,
    input  logic              i_smem_cs,
    input  logic [3:0]        i_smem_sio,
    output logic [3:0]        o_smem_sio,
    output logic              o_smem_sio_oe,
    input  logic              i_smem_ld_en,
    input  logic [ADDR_W-1:0] i_smem_ld_addr,
    input  logic [7:0]        i_smem_ld_data,
    output logic              o_smem_busy
);

    localparam int         DEPTH      = 2**ADDR_W;
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_NIB - 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE} state_t;

    state_t            state_q, state_d;
    logic              sck_q;
    logic              rise, fall;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [19:0]       sh_q, sh_d;     // previously received nibbles, newest in [3:0]
    logic              rd_q, rd_d;     // current command is a read
    logic [3:0]        sio_q, sio_d;
    logic              oe_q, oe_d;
    logic              we;
    logic [7:0]        wdata;
    logic [23:0]       nib_cat;        // received history plus the nibble on the bus now
    logic [7:0]        rbyte;
    logic [7:0]        mem [DEPTH];

    assign rise = i_smem_sck & ~sck_q;
    assign fall = ~i_smem_sck & sck_q;

    assign o_smem_sio    = sio_q;
    assign o_smem_sio_oe = oe_q;
    assign o_smem_busy   = ~i_smem_cs & (state_q != IDLE);

    // Next-state and datapath decode; CS high overrides everything and returns to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        sh_d    = sh_q;
        rd_d    = rd_q;
        sio_d   = sio_q;
        oe_d    = oe_q;
        we      = 1'b0;
        nib_cat = {sh_q, i_smem_sio};
        wdata   = nib_cat[7:0];
        rbyte   = mem[addr_q];
        if (i_smem_cs) begin
            state_d = IDLE;
            cnt_d   = '0;
            addr_d  = '0;
            sh_d    = '0;
            rd_d    = 1'b0;
            sio_d   = '0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = CMD;
                    cnt_d   = '0;
                end
                CMD: if (rise) begin
                    sh_d  = nib_cat[19:0];
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd1) begin
                        cnt_d = '0;
                        if (nib_cat[7:0] == CMD_RD || nib_cat[7:0] == CMD_WR) begin
                            state_d = ADDR;
                            rd_d    = (nib_cat[7:0] == CMD_RD);
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR: if (rise) begin
                    sh_d  = nib_cat[19:0];
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd5) begin
                        // 24-bit address on the wire; bits above the store size are dropped.
                        cnt_d  = '0;
                        addr_d = nib_cat[ADDR_W-1:0];
                        if (!rd_q)
                            state_d = WDATA;
                        else if (DUMMY_NIB == 0)
                            state_d = RDATA;
                        else
                            state_d = DUMMY;
                    end
                end
                DUMMY: if (rise) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == DUMMY_LAST) begin
                        cnt_d   = '0;
                        state_d = RDATA;
                    end
                end
                RDATA: if (fall) begin
                    oe_d = 1'b1;
                    if (!cnt_q[0]) begin
                        sio_d = rbyte[7:4];
                        cnt_d = 8'd1;
                    end else begin
                        sio_d  = rbyte[3:0];
                        cnt_d  = '0;
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
                WDATA: if (rise) begin
                    sh_d = nib_cat[19:0];
                    if (!cnt_q[0]) begin
                        cnt_d = 8'd1;
                    end else begin
                        we     = 1'b1;
                        cnt_d  = '0;
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
                IGNORE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge i_smem_gck or posedge i_smem_rst) begin
        if (i_smem_rst) begin
            state_q <= IDLE;
            sck_q   <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            sh_q    <= '0;
            rd_q    <= 1'b0;
            sio_q   <= '0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sck_q   <= i_smem_sck;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            sh_q    <= sh_d;
            rd_q    <= rd_d;
            sio_q   <= sio_d;
            oe_q    <= oe_d;
        end
    end

    // Store writes; the backdoor write is issued last so it wins on an address clash.
    always_ff @(posedge i_smem_gck) begin
        if (we)
            mem[addr_q] <= wdata;
        if (i_smem_ld_en)
            mem[i_smem_ld_addr] <= i_smem_ld_data;
    end

endmodule
